mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access stage of the IITB-RISC pipeline. It consumes the EX/MEM pipeline register outputs and performs the data-memory write or read for the instruction in MEM. It selects the write-back value and registers the result into the MEM/WB pipeline register feeding register-file write-back. It also drives same-cycle forwarding/hazard signals and latches the halt (stop) condition.

## Interface
Parameters:
- DATA_W, 16, datapath and memory word width
- MEM_ADDR_W, 8, data-memory index width (2^MEM_ADDR_W words)

Ports:
- clk  in  1  stage clock; all state updates on falling edge
- resetn  in  1  asynchronous, active-low reset
- in_Validity  in  1  instruction in MEM is valid
- in_M_addr  in  DATA_W  data-memory word address
- in_ANS_LHI_PC1  in  DATA_W  ALU / LHI / PC+1 result
- in_Data_in  in  DATA_W  store data
- in_RDest  in  3  destination register
- in_mem_ans  in  1  1 = write-back value comes from memory (load)
- in_W_mem  in  1  store enable
- in_W_reg  in  1  register write enable
- in_stop  in  1  halt instruction
- in_pc  in  DATA_W  PC of instruction
- stall_MEM  in  1  hold MEM/WB register and suppress store
- out_Validity_MEM_WB  out  1  registered validity
- out_WB_data  out  DATA_W  registered write-back value
- out_RDest  out  3  registered destination
- out_W_reg  out  1  registered write enable
- out_stop  out  1  registered stop
- out_pc  out  DATA_W  registered PC
- fwd_data  out  DATA_W  combinational MEM-stage result for forwarding
- fwd_RDest  out  3  combinational, = in_RDest
- fwd_W_reg  out  1  combinational, = in_Validity & in_W_reg & !halted
- load_pending  out  1  combinational, = in_Validity & in_mem_ans & in_W_reg
- addr_err  out  1  sticky: valid access with in_M_addr[DATA_W-1:MEM_ADDR_W] != 0
- halted  out  1  sticky: a valid stop has been registered into MEM/WB

## Operation
- Access enable: acc = in_Validity & !halted & (in_W_mem | in_mem_ans). in_range = upper address bits all zero.
- Store: on falling edge, write mem[in_M_addr[MEM_ADDR_W-1:0]] <= in_Data_in when in_Validity & in_W_mem & in_range & !stall_MEM & !halted.
- Load: combinational read rdata = mem[in_M_addr[MEM_ADDR_W-1:0]]. Out of range reads return 0.
- Result: fwd_data = in_mem_ans ? rdata : in_ANS_LHI_PC1.
- addr_err: set on any falling edge with acc & !in_range & !stall_MEM. Cleared only by reset. An erroneous store is dropped; the instruction still retires.
- MEM/WB register, on falling edge, in priority order:
  - resetn low: all registered outputs 0.
  - stall_MEM = 1: hold every register, including validity.
  - halted = 1: hold every register (pipeline frozen).
  - in_Validity = 1: capture fwd_data, in_RDest, in_W_reg, in_stop, in_pc; out_Validity_MEM_WB <= 1.
  - in_Validity = 0 (bubble): out_Validity_MEM_WB <= 0, out_RDest <= 0, out_W_reg <= 0, out_stop <= 0. out_WB_data and out_pc are held.
- halted: set on the edge that captures a valid in_stop (not stalled). Once set, no stores and no register updates occur until reset.

## Timing
- Reset (async): all registered outputs, addr_err and halted go to 0 immediately. Memory contents are not reset.
- Store latency: data is visible to a combinational read by the next instruction after the write edge.
- Load/ALU result to out_WB_data: 1 falling edge.
- Forward signals are valid in the same cycle the instruction sits in MEM.
- Stall on the edge of a store: no write. The write happens on the first non-stalled edge, exactly once.
- Stall asserted with a bubble: the register holds its previous valid contents; the hazard unit must treat out_Validity_MEM_WB as authoritative.
- A store and a load cannot be in MEM in the same cycle. Read-during-write of the same instruction returns pre-write data.
- Reset mid-stall or mid-halt: reset wins; the stage restarts empty.
- Address wrap: none. Upper bits nonzero means error, never aliasing.

## Test plan
- Reset: hold resetn=0 with arbitrary inputs -> all outputs 0. Release, then present a bubble -> outputs stay 0.
- Store then load: SW addr 0x0005 data 0xBEEF; next cycle LW addr 0x0005, mem_ans=1, RDest=3, W_reg=1 -> after 1 edge out_WB_data=0xBEEF, out_RDest=3, out_W_reg=1. load_pending=1 during the LW cycle.
- ALU pass-through: mem_ans=0, ANS=0x1234, RDest=6 -> fwd_data=0x1234 same cycle; out_WB_data=0x1234 after the edge.
- Stall: SW addr 0x10 data 0xAAAA with stall_MEM=1 for 3 edges, then 0 -> memory is written once, after the stall. MEM/WB outputs are unchanged during the 3 stalled edges.
- Bubble and error: valid LW at addr 0x0100 (MEM_ADDR_W=8) -> addr_err=1 sticky, out_WB_data=0. A following bubble -> out_W_reg=0, out_RDest=0.
- Halt: valid stop, then a valid SW addr 0x01 data 0x5555 -> halted=1, out_stop=1. Memory at 0x01 is unchanged and the registers are frozen until resetn pulses low.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs, MEM/WB register outputs and forwarding signals of the MEM stage.
// The master side is the pipeline that feeds the stage; slave is the stage.
interface mem_wb_stage_if #(
    parameter int DATA_W = 16
);
    logic              in_Validity;
    logic [DATA_W-1:0] in_M_addr;
    logic [DATA_W-1:0] in_ANS_LHI_PC1;
    logic [DATA_W-1:0] in_Data_in;
    logic [2:0]        in_RDest;
    logic              in_mem_ans;
    logic              in_W_mem;
    logic              in_W_reg;
    logic              in_stop;
    logic [DATA_W-1:0] in_pc;
    logic              stall_MEM;
    logic              out_Validity_MEM_WB;
    logic [DATA_W-1:0] out_WB_data;
    logic [2:0]        out_RDest;
    logic              out_W_reg;
    logic              out_stop;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] fwd_data;
    logic [2:0]        fwd_RDest;
    logic              fwd_W_reg;
    logic              load_pending;
    logic              addr_err;
    logic              halted;

    modport master (
        output in_Validity, in_M_addr, in_ANS_LHI_PC1, in_Data_in,
        output in_RDest, in_mem_ans, in_W_mem, in_W_reg, in_stop,
        output in_pc, stall_MEM,
        input  out_Validity_MEM_WB, out_WB_data, out_RDest, out_W_reg,
        input  out_stop, out_pc, fwd_data, fwd_RDest, fwd_W_reg,
        input  load_pending, addr_err, halted
    );

    modport slave (
        input  in_Validity, in_M_addr, in_ANS_LHI_PC1, in_Data_in,
        input  in_RDest, in_mem_ans, in_W_mem, in_W_reg, in_stop,
        input  in_pc, stall_MEM,
        output out_Validity_MEM_WB, out_WB_data, out_RDest, out_W_reg,
        output out_stop, out_pc, fwd_data, fwd_RDest, fwd_W_reg,
        output load_pending, addr_err, halted
    );
endinterface

// File: rtl/mem_wb_stage.sv
// IITB-RISC memory stage: data-memory access, MEM/WB register, forwarding
// and sticky halt/address-error flags. State changes on the falling edge.
module mem_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int MEM_ADDR_W = 8
) (
    input logic           clk,
    input logic           resetn,
    mem_wb_stage_if.slave bus
);
    localparam int DEPTH = 1 << MEM_ADDR_W;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] wb_data;
        logic [2:0]        rdest;
        logic              w_reg;
        logic              stop;
        logic [DATA_W-1:0] pc;
    } mem_wb_t;

    mem_wb_t               wb_q;
    logic                  halted_q;
    logic                  addr_err_q;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [MEM_ADDR_W-1:0] idx;
    logic                  in_range;
    logic                  acc;
    logic                  store_en;
    logic [DATA_W-1:0]     rdata;
    logic [DATA_W-1:0]     result;

    assign idx      = bus.in_M_addr[MEM_ADDR_W-1:0];
    assign in_range = ~|bus.in_M_addr[DATA_W-1:MEM_ADDR_W];
    assign acc      = bus.in_Validity & ~halted_q
                    & (bus.in_W_mem | bus.in_mem_ans);
    assign store_en = resetn & bus.in_Validity & bus.in_W_mem
                    & in_range & ~bus.stall_MEM & ~halted_q;

    // Out-of-range addresses never alias onto a real word.
    assign rdata  = in_range ? mem[idx] : '0;
    assign result = bus.in_mem_ans ? rdata : bus.in_ANS_LHI_PC1;

    always_ff @(negedge clk) begin
        if (store_en) begin
            mem[idx] <= bus.in_Data_in;
        end
    end

    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err_q <= 1'b0;
        end else if (acc & ~in_range & ~bus.stall_MEM) begin
            addr_err_q <= 1'b1;
        end
    end

    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_q     <= '0;
            halted_q <= 1'b0;
        end else if (!bus.stall_MEM && !halted_q) begin
            if (bus.in_Validity) begin
                wb_q.vld     <= 1'b1;
                wb_q.wb_data <= result;
                wb_q.rdest   <= bus.in_RDest;
                wb_q.w_reg   <= bus.in_W_reg;
                wb_q.stop    <= bus.in_stop;
                wb_q.pc      <= bus.in_pc;
                halted_q     <= bus.in_stop;
            end else begin
                // Bubble: data and PC keep their last valid values.
                wb_q.vld   <= 1'b0;
                wb_q.rdest <= '0;
                wb_q.w_reg <= 1'b0;
                wb_q.stop  <= 1'b0;
            end
        end
    end

    assign bus.out_Validity_MEM_WB = wb_q.vld;
    assign bus.out_WB_data         = wb_q.wb_data;
    assign bus.out_RDest           = wb_q.rdest;
    assign bus.out_W_reg           = wb_q.w_reg;
    assign bus.out_stop            = wb_q.stop;
    assign bus.out_pc              = wb_q.pc;
    assign bus.fwd_data            = result;
    assign bus.fwd_RDest           = bus.in_RDest;
    assign bus.fwd_W_reg           = bus.in_Validity & bus.in_W_reg
                                   & ~halted_q;
    assign bus.load_pending        = bus.in_Validity & bus.in_mem_ans
                                   & bus.in_W_reg;
    assign bus.addr_err            = addr_err_q;
    assign bus.halted              = halted_q;
endmodule
